// File: rtl/rambus_arb_pkg.sv
// Shared definitions for the rambus two-master arbiter: FSM states, owner codes
// and the rambus bus geometry shared with the rambus RAM and the spell core.
package rambus_arb_pkg;

    localparam int unsigned RAMBUS_ADDR_W = 9;
    localparam int unsigned RAMBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // {valid, id}
    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b10;
    localparam logic [1:0] OWNER_M1   = 2'b11;

    function automatic logic [1:0] owner_code(input arb_state_e state);
        case (state)
            ST_OWN0: owner_code = OWNER_M0;
            ST_OWN1: owner_code = OWNER_M1;
            default: owner_code = OWNER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rambus_arb_timeout.sv
// Wait-cycle counter for the current owner's strobe; expired fires on the
// TIMEOUT-th consecutive wait cycle (cnt_q holds the wait cycles before this one).
module rambus_arb_timeout #(
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expired = en && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/rambus_arbiter.sv
// Two-master Wishbone arbiter in front of the rambus RAM slave: whole-cycle
// round-robin grants, ack masking to non-owners, and hung-transfer timeout abort.
module rambus_arbiter
    import rambus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = RAMBUS_ADDR_W,
    parameter int unsigned DATA_W  = RAMBUS_DATA_W,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic [ADDR_W-1:0]   m0_adr,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_dat_o,

    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic [ADDR_W-1:0]   m1_adr,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_dat_o,

    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [DATA_W/8-1:0] s_sel,
    output logic [ADDR_W-1:0]   s_adr,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_dat_i,

    output logic [1:0]          owner,
    output logic                timeout_flag,
    input  logic                timeout_clr
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       flag_q;

    logic req0, req1;
    logic own0, own1, in_own;
    logic to_en, to_clr, expired;

    logic              own_cyc, own_stb, own_we;
    logic [SEL_W-1:0]  own_sel;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;

    assign req0   = m0_cyc & m0_stb;
    assign req1   = m1_cyc & m1_stb;
    assign own0   = (state_q == ST_OWN0);
    assign own1   = (state_q == ST_OWN1);
    assign in_own = own0 | own1;

    // Current owner's request; only meaningful while in_own.
    assign own_cyc = own1 ? m1_cyc   : m0_cyc;
    assign own_stb = own1 ? m1_stb   : m0_stb;
    assign own_we  = own1 ? m1_we    : m0_we;
    assign own_sel = own1 ? m1_sel   : m0_sel;
    assign own_adr = own1 ? m1_adr   : m0_adr;
    assign own_dat = own1 ? m1_dat_i : m0_dat_i;

    // Counter runs only while the owner is waiting on the slave; any ack, strobe
    // gap, release or abort restarts it.
    assign to_en  = in_own & own_cyc & own_stb & ~s_ack;
    assign to_clr = ~to_en | expired;

    rambus_arb_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .en      (to_en),
        .clr     (to_clr),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (expired) begin
                flag_q <= 1'b1;
            end else if (timeout_clr) begin
                flag_q <= 1'b0;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        s_cyc        = 1'b0;
        s_stb        = 1'b0;
        s_we         = 1'b0;
        s_sel        = '0;
        s_adr        = '0;
        s_dat_o      = '0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    if (last_grant_q) begin
                        state_d      = ST_OWN0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = ST_OWN1;
                        last_grant_d = 1'b1;
                    end
                end else if (req0) begin
                    state_d      = ST_OWN0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = ST_OWN1;
                    last_grant_d = 1'b1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                s_cyc   = own_cyc & ~expired;
                s_stb   = own_cyc & own_stb & ~expired;
                s_we    = own_we;
                s_sel   = own_sel;
                s_adr   = own_adr;
                s_dat_o = own_dat;
                if (own1) begin
                    m1_ack = s_ack & own_cyc & own_stb;
                    m1_err = expired;
                end else begin
                    m0_ack = s_ack & own_cyc & own_stb;
                    m0_err = expired;
                end
                // Leaving through IDLE guarantees s_cyc low for at least one cycle.
                if (!own_cyc || expired) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            s_cyc   = 1'b0;
            s_stb   = 1'b0;
            s_we    = 1'b0;
            s_sel   = '0;
            s_adr   = '0;
            s_dat_o = '0;
            m0_ack  = 1'b0;
            m1_ack  = 1'b0;
            m0_err  = 1'b0;
            m1_err  = 1'b0;
        end
    end

    assign owner        = reset ? OWNER_IDLE : owner_code(state_q);
    assign timeout_flag = flag_q & ~reset;
    assign m0_dat_o     = reset ? '0 : s_dat_i;
    assign m1_dat_o     = reset ? '0 : s_dat_i;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Scenario bench for rambus_arbiter: expected slave beats are queued when a
// request is driven and popped when the slave acks.
module tb_rambus_arbiter;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = DATA_W / 8;
    localparam int TIMEOUT = 255;

    logic              clock, reset;
    logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [SEL_W-1:0]  m0_sel, m1_sel, s_sel;
    logic [ADDR_W-1:0] m0_adr, m1_adr, s_adr;
    logic [DATA_W-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic              s_cyc, s_stb, s_we, s_ack;
    logic [1:0]        owner;
    logic              timeout_flag, timeout_clr;

    typedef struct {
        logic              id;
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
    } beat_t;

    beat_t sb_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    rambus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(8)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_dat_o(m0_dat_o),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_dat_o(m1_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_ack(s_ack), .s_dat_i(s_dat_i),
        .owner(owner), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic drive_m(input logic id, input logic cyc, input logic stb, input logic we,
                           input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat,
                           input logic [SEL_W-1:0] sel);
        if (id) begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_i = dat; m1_sel = sel;
        end else begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_i = dat; m0_sel = sel;
        end
    endtask

    task automatic push_beat(input logic id, input logic we, input logic [ADDR_W-1:0] adr,
                             input logic [DATA_W-1:0] dat, input logic [SEL_W-1:0] sel);
        beat_t b;
        b.id = id; b.we = we; b.adr = adr; b.dat = dat; b.sel = sel;
        sb_q.push_back(b);
    endtask

    // Called at a sample point where the slave is acking; pops the expected beat.
    task automatic expect_beat(input string tag);
        beat_t       e;
        logic        ack_own, ack_other;
        logic [DATA_W-1:0] rd;
        total_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s_sb_empty: got ack with no queued beat want queued beat", tag);
            return;
        end
        pass_cnt++;
        e         = sb_q.pop_front();
        ack_own   = e.id ? m1_ack : m0_ack;
        ack_other = e.id ? m0_ack : m1_ack;
        rd        = e.id ? m1_dat_o : m0_dat_o;
        total_cnt++; if (owner !== {1'b1, e.id}) $display("FAIL %s_owner: got %b want %b", tag, owner, {1'b1, e.id}); else pass_cnt++;
        total_cnt++; if (s_stb !== 1'b1) $display("FAIL %s_s_stb: got %b want 1", tag, s_stb); else pass_cnt++;
        total_cnt++; if (s_adr !== e.adr) $display("FAIL %s_s_adr: got %h want %h", tag, s_adr, e.adr); else pass_cnt++;
        total_cnt++; if (s_we !== e.we) $display("FAIL %s_s_we: got %b want %b", tag, s_we, e.we); else pass_cnt++;
        total_cnt++; if (s_sel !== e.sel) $display("FAIL %s_s_sel: got %h want %h", tag, s_sel, e.sel); else pass_cnt++;
        total_cnt++; if (ack_own !== 1'b1) $display("FAIL %s_ack_owner: got %b want 1", tag, ack_own); else pass_cnt++;
        total_cnt++; if (ack_other !== 1'b0) $display("FAIL %s_ack_other: got %b want 0", tag, ack_other); else pass_cnt++;
        if (e.we) begin
            total_cnt++; if (s_dat_o !== e.dat) $display("FAIL %s_wdata: got %h want %h", tag, s_dat_o, e.dat); else pass_cnt++;
        end else begin
            total_cnt++; if (rd !== e.dat) $display("FAIL %s_rdata: got %h want %h", tag, rd, e.dat); else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; timeout_clr = 1'b0; s_ack = 1'b1; s_dat_i = 32'h0;
        drive_m(1'b0, 1'b1, 1'b1, 1'b1, 9'h1, 32'h1, 4'hF);
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        tick(); tick(); sample();
        total_cnt++; if (owner !== 2'b00) $display("FAIL rst_owner: got %b want 00", owner); else pass_cnt++;
        total_cnt++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL rst_s_cyc_stb: got %b%b want 00", s_cyc, s_stb); else pass_cnt++;
        total_cnt++; if (m0_ack !== 1'b0 || m0_err !== 1'b0) $display("FAIL rst_m0_ack_err: got %b%b want 00", m0_ack, m0_err); else pass_cnt++;
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL rst_flag: got %b want 0", timeout_flag); else pass_cnt++;
        tick();
        s_ack = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        tick();
        drive_m(1'b0, 1'b1, 1'b1, 1'b1, 9'h012, 32'hDEADBEEF, 4'hF);
        push_beat(1'b0, 1'b1, 9'h012, 32'hDEADBEEF, 4'hF);
        sample();
        total_cnt++; if (s_stb !== 1'b0) $display("FAIL wr_grant_latency: got s_stb %b want 0", s_stb); else pass_cnt++;
        tick(); sample();
        total_cnt++; if (s_stb !== 1'b1) $display("FAIL wr_s_stb: got %b want 1", s_stb); else pass_cnt++;
        total_cnt++; if (owner !== 2'b10) $display("FAIL wr_owner: got %b want 10", owner); else pass_cnt++;
        total_cnt++; if (m0_ack !== 1'b0) $display("FAIL wr_early_ack: got %b want 0", m0_ack); else pass_cnt++;
        tick();
        s_ack = 1'b1;
        sample();
        expect_beat("wr");
        tick();
        s_ack = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        sample();
        total_cnt++; if (s_cyc !== 1'b0) $display("FAIL wr_release_cyc: got %b want 0", s_cyc); else pass_cnt++;
        tick(); sample();
        total_cnt++; if (owner !== 2'b00) $display("FAIL wr_idle_owner: got %b want 00", owner); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic              lg_model;
        logic              winner;
        logic [ADDR_W-1:0] adr [2];
        adr[0] = 9'h020;
        adr[1] = 9'h030;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lg_model = 1'b1;
        drive_m(1'b0, 1'b1, 1'b1, 1'b0, adr[0], 32'h0, 4'hF);
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, adr[1], 32'h0, 4'hF);
        for (int r = 0; r < 3; r++) begin
            winner   = ~lg_model;
            lg_model = winner;
            sample();
            total_cnt++; if (owner !== 2'b00) $display("FAIL rr%0d_idle: got %b want 00", r, owner); else pass_cnt++;
            tick();
            s_ack   = 1'b1;
            s_dat_i = 32'hA000_0000 + 32'(r);
            push_beat(winner, 1'b0, adr[winner], s_dat_i, 4'hF);
            sample();
            expect_beat($sformatf("rr%0d", r));
            tick();
            s_ack = 1'b0;
            drive_m(winner, 1'b0, 1'b0, 1'b0, adr[winner], 32'h0, 4'hF);
            sample();
            total_cnt++; if (s_cyc !== 1'b0) $display("FAIL rr%0d_release: got %b want 0", r, s_cyc); else pass_cnt++;
            tick();
            drive_m(winner, 1'b1, 1'b1, 1'b0, adr[winner], 32'h0, 4'hF);
        end
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        tick(); tick();
    endtask

    task automatic test_burst_hold();
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 32'h0, 4'hF);
        sample();
        total_cnt++; if (owner !== 2'b00) $display("FAIL burst_idle: got %b want 00", owner); else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == 0) drive_m(1'b0, 1'b1, 1'b1, 1'b0, 9'h040, 32'h0, 4'hF);
            m1_adr  = 9'(b);
            s_ack   = 1'b1;
            s_dat_i = 32'hB000_0000 + 32'(b);
            push_beat(1'b1, 1'b0, 9'(b), s_dat_i, 4'hF);
            sample();
            expect_beat($sformatf("burst%0d", b));
        end
        tick();
        s_ack = 1'b0;
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        sample();
        total_cnt++; if (s_cyc !== 1'b0) $display("FAIL burst_release: got %b want 0", s_cyc); else pass_cnt++;
        tick(); sample();
        total_cnt++; if (owner !== 2'b00 || s_cyc !== 1'b0) $display("FAIL burst_gap: got owner %b cyc %b want 00 0", owner, s_cyc); else pass_cnt++;
        tick();
        s_ack   = 1'b1;
        s_dat_i = 32'hC000_00C0;
        push_beat(1'b0, 1'b0, 9'h040, s_dat_i, 4'hF);
        sample();
        expect_beat("burst_m0");
        tick();
        s_ack = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_timeout();
        int err_at;
        err_at = 0;
        drive_m(1'b0, 1'b1, 1'b1, 1'b1, 9'h055, 32'h0000_1234, 4'hF);
        for (int c = 0; c < 300 && err_at == 0; c++) begin
            tick(); sample();
            if (m0_err === 1'b1) begin
                err_at = c + 1;
                total_cnt++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL to_abort_bus: got %b%b want 00", s_cyc, s_stb); else pass_cnt++;
                total_cnt++; if (m1_err !== 1'b0) $display("FAIL to_m1_err: got %b want 0", m1_err); else pass_cnt++;
            end
        end
        total_cnt++; if (err_at != TIMEOUT) $display("FAIL to_err_cycle: got %0d want %0d", err_at, TIMEOUT); else pass_cnt++;
        tick();
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        sample();
        total_cnt++; if (timeout_flag !== 1'b1) $display("FAIL to_flag_set: got %b want 1", timeout_flag); else pass_cnt++;
        total_cnt++; if (owner !== 2'b00 || m0_err !== 1'b0) $display("FAIL to_after: got owner %b err %b want 00 0", owner, m0_err); else pass_cnt++;
        tick(); tick(); tick(); sample();
        total_cnt++; if (timeout_flag !== 1'b1) $display("FAIL to_flag_sticky: got %b want 1", timeout_flag); else pass_cnt++;
        tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        sample();
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL to_flag_clr: got %b want 0", timeout_flag); else pass_cnt++;
        drive_m(1'b1, 1'b1, 1'b1, 1'b1, 9'h066, 32'hCAFEF00D, 4'h3);
        push_beat(1'b1, 1'b1, 9'h066, 32'hCAFEF00D, 4'h3);
        tick();
        s_ack = 1'b1;
        sample();
        expect_beat("to_m1");
        tick();
        s_ack = 1'b0;
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        // Expiry with timeout_clr held: the set must win.
        drive_m(1'b0, 1'b1, 1'b1, 1'b0, 9'h011, 32'h0, 4'hF);
        timeout_clr = 1'b1;
        for (int c = 0; c < TIMEOUT; c++) tick();
        sample();
        total_cnt++; if (m0_err !== 1'b1) $display("FAIL rm_err: got %b want 1", m0_err); else pass_cnt++;
        tick();
        timeout_clr = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        sample();
        total_cnt++; if (timeout_flag !== 1'b1) $display("FAIL rm_set_wins: got %b want 1", timeout_flag); else pass_cnt++;
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, 9'h077, 32'h0, 4'hF);
        tick(); sample();
        total_cnt++; if (owner !== 2'b11 || s_stb !== 1'b1) $display("FAIL rm_own1: got owner %b stb %b want 11 1", owner, s_stb); else pass_cnt++;
        tick();
        reset = 1'b1;
        sample();
        total_cnt++; if (owner !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL rm_reset_out: got owner %b cyc %b stb %b want 00 0 0", owner, s_cyc, s_stb); else pass_cnt++;
        total_cnt++; if (timeout_flag !== 1'b0) $display("FAIL rm_reset_flag: got %b want 0", timeout_flag); else pass_cnt++;
        tick();
        reset = 1'b0;
        s_ack = 1'b1;
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        sample();
        total_cnt++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) $display("FAIL rm_late_ack: got %b%b want 00", m0_ack, m1_ack); else pass_cnt++;
        total_cnt++; if (owner !== 2'b00 || timeout_flag !== 1'b0) $display("FAIL rm_after: got owner %b flag %b want 00 0", owner, timeout_flag); else pass_cnt++;
        tick();
        s_ack = 1'b0;
        // last_grant is back to 1 even though m1 owned last: m0 wins the tie.
        drive_m(1'b0, 1'b1, 1'b1, 1'b0, 9'h0A0, 32'h0, 4'hF);
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, 9'h0B0, 32'h0, 4'hF);
        tick();
        s_ack   = 1'b1;
        s_dat_i = 32'h5A5A_0001;
        push_beat(1'b0, 1'b0, 9'h0A0, s_dat_i, 4'hF);
        sample();
        expect_beat("rm_tie");
        tick();
        s_ack = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        drive_m(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
        tick(); tick(); sample();
        total_cnt++; if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d left want 0", sb_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_hold();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
